// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  divider_pkg
//  Shared FSM encodings and iteration constants for the restoring divider.
//  Revision: 1.0
// ============================================================================
package divider_pkg;

    localparam int DIV_DATA_WIDTH = 8;
    localparam int ITER_COUNT     = 2 * DIV_DATA_WIDTH;

    // Counter must hold the full iteration count, not just count-1.
    function automatic int cnt_width(input int iters);
        return $clog2(iters + 1);
    endfunction

    localparam int CNT_WIDTH = cnt_width(ITER_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_sub_stage.sv
`default_nettype none
// ============================================================================
//  div_sub_stage
//  Combinational trial subtract of one restoring-division step.
//  Revision: 1.0
// ============================================================================
module div_sub_stage
    import divider_pkg::*;
#(
    parameter int WIDTH = ITER_COUNT
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    logic [WIDTH+1:0] w_ext;

    assign w_ext  = {1'b0, i_rem} - {2'b00, i_divisor};
    assign o_diff = w_ext[WIDTH-1:0];
    // A difference that cannot fit the WIDTH-bit partial remainder is a failed trial.
    assign o_borrow = w_ext[WIDTH+1] | w_ext[WIDTH];

endmodule
`default_nettype wire

// File: rtl/restoring_divider_16bit.sv
`default_nettype none
// ============================================================================
//  restoring_divider_16bit
//  Sequential unsigned restoring divider, one quotient bit per clock.
//  Option: DIVIDER_DIVZERO_DETECT_EN short-circuits a zero divisor to DONE.
//  Revision: 1.0
// ============================================================================
module restoring_divider_16bit
    import divider_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] inData_A,
    input  logic [2*DATA_WIDTH-1:0] inData_B,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] quotient,
    output logic [2*DATA_WIDTH-1:0] remainder,
    output logic                    div_by_zero
);

    localparam int c_W     = 2 * DATA_WIDTH;
    localparam int c_CNT_W = cnt_width(c_W);

    div_state_t         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_W-1:0]     r_dividend;
    logic [c_W-1:0]     r_divisor;
    logic [c_W-1:0]     r_rem;
    logic [c_W-1:0]     r_quotient;
    logic [c_W-1:0]     r_remainder;
    logic               r_busy;
    logic               r_done;
    logic               r_div_by_zero;

    logic [c_W:0]       w_shift;
    logic [c_W-1:0]     w_diff;
    logic               w_borrow;
    logic [c_W-1:0]     w_next_rem;
    logic [c_W-1:0]     w_next_quo;
    logic               w_divzero_req;

`ifdef DIVIDER_DIVZERO_DETECT_EN
    assign w_divzero_req = (inData_B == '0);
`else
    assign w_divzero_req = 1'b0;
`endif

    // The dividend register doubles as the quotient shift register.
    assign w_shift    = {r_rem, r_dividend[c_W-1]};
    assign w_next_rem = w_borrow ? w_shift[c_W-1:0] : w_diff;
    assign w_next_quo = {r_dividend[c_W-2:0], ~w_borrow};

    div_sub_stage #(
        .WIDTH (c_W)
    ) u_sub (
        .i_rem     (w_shift),
        .i_divisor (r_divisor),
        .o_diff    (w_diff),
        .o_borrow  (w_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_divzero_req) begin
                            r_quotient    <= '1;
                            r_remainder   <= inData_A;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= ST_DONE;
                        end else begin
                            r_dividend <= inData_A;
                            r_divisor  <= inData_B;
                            r_rem      <= '0;
                            r_cnt      <= c_CNT_W'(c_W);
                            r_busy     <= 1'b1;
                            r_state    <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_dividend <= w_next_quo;
                    r_rem      <= w_next_rem;
                    r_cnt      <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_quotient    <= w_next_quo;
                        r_remainder   <= w_next_rem;
                        r_div_by_zero <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_restoring_divider_16bit.sv
`default_nettype none
// ============================================================================
//  tb_restoring_divider_16bit
//  Directed self-checking bench for restoring_divider_16bit.
//  Revision: 1.0
// ============================================================================
module tb_restoring_divider_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] inData_A;
    logic [15:0] inData_B;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks;
    int n_fail;

    restoring_divider_16bit #(
        .DATA_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .inData_A    (inData_A),
        .inData_B    (inData_B),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVIDER_DIVZERO_DETECT_EN
    localparam int  c_DZ_LAT  = 0;
    localparam logic c_DZ_FLAG = 1'b1;
`else
    localparam int  c_DZ_LAT  = 16;
    localparam logic c_DZ_FLAG = 1'b0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for done after the start edge; lat counts edges after that edge.
    task automatic wait_done(input string tag, input int lat);
        int  n;
        bit  seen;
        n    = 0;
        seen = done;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            seen = done;
        end
        check_eq({tag, "_seen"}, seen, 1);
        check_eq({tag, "_lat"}, n, lat);
    endtask

    task automatic run_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input int lat, input logic [15:0] q, input logic [15:0] r,
                           input logic dz);
        @(negedge clk);
        inData_A = a;
        inData_B = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy"}, busy, (lat > 0) ? 1 : 0);
        wait_done(tag, lat);
        check_eq({tag, "_q"}, quotient, q);
        check_eq({tag, "_r"}, remainder, r);
        check_eq({tag, "_dz"}, div_by_zero, dz);
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, done, 0);
        check_eq({tag, "_q_hold"}, quotient, q);
    endtask

    initial begin
        int  n;
        int  pulses;
        bit  seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        inData_A = '0;
        inData_B = '0;

        #3 rst_n = 1'b0;
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_q", quotient, 0);
        check_eq("rst_r", remainder, 0);
        check_eq("rst_dz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run_div("d100_7",   16'd100,  16'd7,      16, 16'd14,   16'd2,    1'b0);
        run_div("dffff_1",  16'hFFFF, 16'd1,      16, 16'hFFFF, 16'h0000, 1'b0);
        run_div("d5_1000",  16'd5,    16'h1000,   16, 16'd0,    16'd5,    1'b0);
        run_div("d1234eq",  16'h1234, 16'h1234,   16, 16'd1,    16'd0,    1'b0);
        run_div("d1234_0",  16'd1234, 16'd0, c_DZ_LAT, 16'hFFFF, 16'd1234, c_DZ_FLAG);

        // start held high with new operands for the whole calculation
        @(negedge clk);
        inData_A = 16'd100;
        inData_B = 16'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        inData_A = 16'd9;
        inData_B = 16'd3;
        n      = 0;
        pulses = 0;
        seen   = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == 8) check_eq("held_q_mid", quotient, 16'hFFFF);
            if (done) begin
                seen = 1'b1;
                pulses++;
            end
        end
        start = 1'b0;
        check_eq("held_lat", n, 16);
        check_eq("held_q", quotient, 16'd14);
        check_eq("held_r", remainder, 16'd2);
        @(posedge clk); #1;
        if (done) pulses++;
        check_eq("held_pulses", pulses, 1);
        run_div("d9_3", 16'd9, 16'd3, 16, 16'd3, 16'd0, 1'b0);

        // reset in the 8th calculation cycle aborts the division
        @(negedge clk);
        inData_A = 16'd100;
        inData_B = 16'd7;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_q", quotient, 0);
        check_eq("abort_r", remainder, 0);
        check_eq("abort_dz", div_by_zero, 0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        check_eq("abort_no_done", seen, 0);
        run_div("d50_6", 16'd50, 16'd6, 16, 16'd8, 16'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
